leaves_mem_stream: RTL and testbench

Parametrised successor to the leaf storage of the k-d tree search engine. Holds NUM_LEAVES leaves of LEAF_SIZE patches, each stored as {idx, patch}.
- Loaded by a single valid/ready stream with an internal leaf/slot counter, so the loader no longer drives per-bank chip selects.
- Serves NUM_RD_PORTS independent leaf-read ports with registered, valid-tagged responses.
- Sits between the tree-build loader and the parallel leaf-distance units.

---
 rtl/leaves_mem_pkg.sv | 22 ++
 rtl/leaves_mem_bank.sv | 50 +++++
 rtl/leaves_mem_stream.sv | 185 ++++++++++++++++++
 tb/tb_leaves_mem_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaves_mem_pkg.sv
// Shared constants, FSM state encoding and leaf-entry layout for the leaf store.
package leaves_mem_pkg;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_IDX_WIDTH  = 9;
  localparam int DEF_LEAF_SIZE  = 8;
  localparam int DEF_PATCH_SIZE = 5;
  localparam int DEF_NUM_LEAVES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Stored word layout: patch in the low bits, idx above it.
  typedef struct packed {
    logic [DEF_IDX_WIDTH-1:0]                 idx;
    logic [DEF_PATCH_SIZE*DEF_DATA_WIDTH-1:0] patch;
  } leaf_entry_t;

endpackage

// File: rtl/leaves_mem_bank.sv
// One slot bank: single write port, NUM_RD_PORTS registered read ports.
// Out-of-range read addresses return an all-zero word.
module leaves_mem_bank #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 64,
  parameter int ADDRW        = 6,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [ADDRW-1:0]              waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [NUM_RD_PORTS-1:0]       re,
  input  logic [NUM_RD_PORTS*ADDRW-1:0] raddr,
  output logic [NUM_RD_PORTS*WIDTH-1:0] rdata
);

  localparam logic [ADDRW:0] DEPTH_EXT = (ADDRW+1)'(DEPTH);

  logic [WIDTH-1:0]              mem_q [DEPTH];
  logic [NUM_RD_PORTS*WIDTH-1:0] rdata_q;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read registers hold their value when a port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (re[p]) begin
          if ({1'b0, raddr[p*ADDRW +: ADDRW]} < DEPTH_EXT) begin
            rdata_q[p*WIDTH +: WIDTH] <= mem_q[raddr[p*ADDRW +: ADDRW]];
          end else begin
            rdata_q[p*WIDTH +: WIDTH] <= '0;
          end
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/leaves_mem_stream.sv
// Leaf storage loaded by one valid/ready stream and read by NUM_RD_PORTS ports.
// Optional macro LEAVES_MEM_OUT_REG_EN adds a second output stage (latency 2).
module leaves_mem_stream
  import leaves_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH    = DEF_IDX_WIDTH,
  parameter int LEAF_SIZE    = DEF_LEAF_SIZE,
  parameter int PATCH_SIZE   = DEF_PATCH_SIZE,
  parameter int NUM_LEAVES   = DEF_NUM_LEAVES,
  parameter int LEAF_ADDRW   = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  load_start,
  input  logic                                                  wr_valid,
  output logic                                                  wr_ready,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0]                      wr_patch,
  input  logic [IDX_WIDTH-1:0]                                  wr_idx,
  output logic                                                  load_done,
  output logic [LEAF_ADDRW:0]                                   leaves_loaded,
  input  logic [NUM_RD_PORTS-1:0]                               rd_req,
  input  logic [NUM_RD_PORTS*LEAF_ADDRW-1:0]                    rd_addr,
  output logic [NUM_RD_PORTS-1:0]                               rd_rvalid,
  output logic [NUM_RD_PORTS*LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] rd_patch_data,
  output logic [NUM_RD_PORTS*LEAF_SIZE*IDX_WIDTH-1:0]           rd_patch_idx
);

  localparam int PATCH_W = PATCH_SIZE * DATA_WIDTH;
  localparam int ENTRY_W = PATCH_W + IDX_WIDTH;
  localparam int SLOTW   = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;
  localparam int PDATA_W = LEAF_SIZE * PATCH_W;
  localparam int PIDX_W  = LEAF_SIZE * IDX_WIDTH;

  localparam logic [SLOTW-1:0]      LAST_SLOT = SLOTW'(LEAF_SIZE - 1);
  localparam logic [LEAF_ADDRW-1:0] LAST_LEAF = LEAF_ADDRW'(NUM_LEAVES - 1);

  state_e                  state_q, state_d;
  logic [SLOTW-1:0]        slot_q, slot_d;
  logic [LEAF_ADDRW-1:0]   leaf_q, leaf_d;
  logic [LEAF_ADDRW:0]     loaded_q, loaded_d;
  logic                    done_q, done_d;
  logic [NUM_RD_PORTS-1:0] rvalid_q;

  logic                    wr_fire_s;
  logic [NUM_RD_PORTS-1:0] rd_fire_s;
  logic [ENTRY_W-1:0]      wr_entry_s;
  logic [NUM_RD_PORTS*ENTRY_W-1:0] bank_rdata_s [LEAF_SIZE];
  logic [NUM_RD_PORTS*PDATA_W-1:0] data_s;
  logic [NUM_RD_PORTS*PIDX_W-1:0]  idx_s;

  assign wr_fire_s  = (state_q == ST_LOAD) && wr_valid;
  assign rd_fire_s  = rd_req & {NUM_RD_PORTS{state_q == ST_READY}};
  assign wr_entry_s = {wr_idx, wr_patch};

  // Load sequencing: slot counter inside a leaf, leaf counter across leaves.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    leaf_d   = leaf_q;
    loaded_d = loaded_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          slot_d   = '0;
          leaf_d   = '0;
          loaded_d = '0;
          done_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          // A beat accepted this cycle is still written; counters restart.
          slot_d   = '0;
          leaf_d   = '0;
          loaded_d = '0;
        end else if (wr_valid) begin
          if (slot_q == LAST_SLOT) begin
            slot_d   = '0;
            loaded_d = loaded_q + (LEAF_ADDRW+1)'(1);
            if (leaf_q == LAST_LEAF) begin
              leaf_d  = '0;
              state_d = ST_READY;
              done_d  = 1'b1;
            end else begin
              leaf_d = leaf_q + LEAF_ADDRW'(1);
            end
          end else begin
            slot_d = slot_q + SLOTW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      leaf_q   <= '0;
      loaded_q <= '0;
      done_q   <= 1'b0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      leaf_q   <= leaf_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      rvalid_q <= rd_fire_s;
    end
  end

  for (genvar s = 0; s < LEAF_SIZE; s++) begin : g_bank
    leaves_mem_bank #(
      .WIDTH       (ENTRY_W),
      .DEPTH       (NUM_LEAVES),
      .ADDRW       (LEAF_ADDRW),
      .NUM_RD_PORTS(NUM_RD_PORTS)
    ) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_fire_s && (slot_q == SLOTW'(s))),
      .waddr(leaf_q),
      .wdata(wr_entry_s),
      .re   (rd_fire_s),
      .raddr(rd_addr),
      .rdata(bank_rdata_s[s])
    );

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_unpack
      assign data_s[(p*LEAF_SIZE+s)*PATCH_W +: PATCH_W] =
        bank_rdata_s[s][p*ENTRY_W +: PATCH_W];
      assign idx_s[(p*LEAF_SIZE+s)*IDX_WIDTH +: IDX_WIDTH] =
        bank_rdata_s[s][p*ENTRY_W+PATCH_W +: IDX_WIDTH];
    end
  end

  assign wr_ready      = (state_q == ST_LOAD);
  assign load_done     = done_q;
  assign leaves_loaded = loaded_q;

`ifdef LEAVES_MEM_OUT_REG_EN
  logic [NUM_RD_PORTS-1:0]         rvalid2_q;
  logic [NUM_RD_PORTS*PDATA_W-1:0] data2_q;
  logic [NUM_RD_PORTS*PIDX_W-1:0]  idx2_q;

  // Second output stage; loads only behind a valid first-stage response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid2_q <= '0;
      data2_q   <= '0;
      idx2_q    <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rvalid_q[p]) begin
          data2_q[p*PDATA_W +: PDATA_W] <= data_s[p*PDATA_W +: PDATA_W];
          idx2_q[p*PIDX_W +: PIDX_W]    <= idx_s[p*PIDX_W +: PIDX_W];
        end
      end
    end
  end

  assign rd_rvalid     = rvalid2_q;
  assign rd_patch_data = data2_q;
  assign rd_patch_idx  = idx2_q;
`else
  assign rd_rvalid     = rvalid_q;
  assign rd_patch_data = data_s;
  assign rd_patch_idx  = idx_s;
`endif

endmodule

// File: tb/tb_leaves_mem_stream.sv
// Randomised bench for leaves_mem_stream with a beat-count behavioural model.
module tb_leaves_mem_stream;

  localparam int DW  = 11;
  localparam int IW  = 9;
  localparam int LS  = 8;
  localparam int PS  = 5;
  localparam int NL  = 5;
  localparam int AW  = 3;
  localparam int NP  = 2;
  localparam int PW  = PS * DW;
  localparam int EW  = PW + IW;
  localparam int LW  = LS * EW;
`ifdef LEAVES_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   load_start;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [PW-1:0]          wr_patch;
  logic [IW-1:0]          wr_idx;
  logic                   load_done;
  logic [AW:0]            leaves_loaded;
  logic [NP-1:0]          rd_req;
  logic [NP*AW-1:0]       rd_addr;
  logic [NP-1:0]          rd_rvalid;
  logic [NP*LS*PW-1:0]    rd_patch_data;
  logic [NP*LS*IW-1:0]    rd_patch_idx;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  leaves_mem_stream #(
    .DATA_WIDTH  (DW),
    .IDX_WIDTH   (IW),
    .LEAF_SIZE   (LS),
    .PATCH_SIZE  (PS),
    .NUM_LEAVES  (NL),
    .LEAF_ADDRW  (AW),
    .NUM_RD_PORTS(NP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_patch     (wr_patch),
    .wr_idx       (wr_idx),
    .load_done    (load_done),
    .leaves_loaded(leaves_loaded),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_rvalid    (rd_rvalid),
    .rd_patch_data(rd_patch_data),
    .rd_patch_idx (rd_patch_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: load progress is a single running beat count.
  logic [EW-1:0] mem_m [NL][LS];
  bit            m_loading, m_ready, m_done;
  int            m_beats;
  logic [LW-1:0] pipe_e [LAT][NP];
  bit            pipe_v [LAT][NP];
  logic [LW-1:0] out_e  [NP];
  bit            out_v  [NP];

  always @(posedge clk or negedge rst_n) begin : model
    logic [LW-1:0] new_e [NP];
    bit            new_v [NP];
    int            a;
    if (!rst_n) begin
      m_loading = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_beats = 0;
      for (int i = 0; i < LAT; i++)
        for (int p = 0; p < NP; p++) begin pipe_e[i][p] = '0; pipe_v[i][p] = 1'b0; end
      for (int p = 0; p < NP; p++) begin out_e[p] = '0; out_v[p] = 1'b0; end
    end else begin
      for (int p = 0; p < NP; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        new_v[p] = rd_req[p] && m_ready;
        new_e[p] = '0;
        if (new_v[p] && a < NL)
          for (int s = 0; s < LS; s++) new_e[p][s*EW +: EW] = mem_m[a][s];
      end
      if (m_loading && wr_valid) begin
        mem_m[m_beats / LS][m_beats % LS] = {wr_idx, wr_patch};
        m_beats++;
      end
      if (load_start) begin
        m_loading = 1'b1; m_ready = 1'b0; m_done = 1'b0; m_beats = 0;
      end else if (m_loading && m_beats == NL * LS) begin
        m_loading = 1'b0; m_ready = 1'b1; m_done = 1'b1;
      end
      for (int i = LAT - 1; i > 0; i--)
        for (int p = 0; p < NP; p++) begin
          pipe_e[i][p] = pipe_e[i-1][p]; pipe_v[i][p] = pipe_v[i-1][p];
        end
      for (int p = 0; p < NP; p++) begin
        pipe_e[0][p] = new_e[p]; pipe_v[0][p] = new_v[p];
        out_v[p] = pipe_v[LAT-1][p];
        if (out_v[p]) out_e[p] = pipe_e[LAT-1][p];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [LS*PW-1:0] ed;
    logic [LS*IW-1:0] ei;
    if (rst_n && chk_en) begin
      chk("wr_ready", 512'(wr_ready), 512'(m_loading));
      chk("load_done", 512'(load_done), 512'(m_done));
      chk("leaves_loaded", 512'(leaves_loaded),
          512'(m_loading ? (m_beats / LS) : (m_done ? NL : 0)));
      for (int p = 0; p < NP; p++) begin
        for (int s = 0; s < LS; s++) begin
          ed[s*PW +: PW] = out_e[p][s*EW +: PW];
          ei[s*IW +: IW] = out_e[p][s*EW+PW +: IW];
        end
        chk($sformatf("rd_rvalid[%0d]", p), 512'(rd_rvalid[p]), 512'(out_v[p]));
        chk($sformatf("rd_patch_data[%0d]", p), 512'(rd_patch_data[p*LS*PW +: LS*PW]), 512'(ed));
        chk($sformatf("rd_patch_idx[%0d]", p), 512'(rd_patch_idx[p*LS*IW +: LS*IW]), 512'(ei));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_rand();
    wr_idx   = IW'($urandom);
    wr_patch = PW'({$urandom, $urandom});
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic load_beats(input int n, input bit toggle);
    int b;
    int k;
    b = 0;
    k = 0;
    while (b < n) begin
      wr_valid = toggle ? ((k % 2) == 0) : 1'b1;
      beat_rand();
      step();
      if (wr_valid) b++;
      k++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      rd_req  = NP'($urandom);
      rd_addr = NP*AW'($urandom);
      step();
    end
    rd_req = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wr_ready"}, 512'(wr_ready), 512'(0));
    chk({tag, "_load_done"}, 512'(load_done), 512'(0));
    chk({tag, "_leaves_loaded"}, 512'(leaves_loaded), 512'(0));
    chk({tag, "_rd_rvalid"}, 512'(rd_rvalid), 512'(0));
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; wr_valid = 1'b0;
    wr_patch = '0; wr_idx = '0; rd_req = '0; rd_addr = '0;
    #12;
    reset_checks("reset");
    chk("reset_data", 512'(rd_patch_data), 512'(0));
    chk("reset_idx", 512'(rd_patch_idx), 512'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Deterministic load: idx = beat, every patch element = beat.
    pulse_start();
    for (int b = 0; b < NL * LS; b++) begin
      wr_valid = 1'b1;
      wr_idx   = IW'(b);
      wr_patch = {PS{DW'(b)}};
      step();
      if (b == NL * LS - 2) chk("done_before_last", 512'(load_done), 512'(0));
    end
    wr_valid = 1'b0;
    chk("done_after_last", 512'(load_done), 512'(1));
    chk("loaded_after_last", 512'(leaves_loaded), 512'(NL));
    chk("ready_after_last", 512'(wr_ready), 512'(0));

    // Same leaf on both ports.
    rd_req  = 2'b11;
    rd_addr = {3'd2, 3'd2};
    step();
    rd_req = '0;
    repeat (LAT - 1) step();
    chk("dual_rvalid", 512'(rd_rvalid), 512'(3));
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < LS; s++) begin
        chk("dual_idx", 512'(rd_patch_idx[(p*LS+s)*IW +: IW]), 512'(16 + s));
        chk("dual_elem", 512'(rd_patch_data[(p*LS+s)*PW +: DW]), 512'(16 + s));
      end

    // Out-of-range leaf addresses return zeros.
    rd_req  = 2'b11;
    rd_addr = {3'd5, 3'd6};
    step();
    rd_req = '0;
    repeat (LAT - 1) step();
    chk("oor_rvalid", 512'(rd_rvalid), 512'(3));
    chk("oor_data", 512'(rd_patch_data[LS*PW-1:0]), 512'(0));
    chk("oor_idx", 512'(rd_patch_idx), 512'(0));
    rand_reads(40);

    // Restart from READY while a read is in flight, then read during LOAD.
    rd_req     = 2'b11;
    rd_addr    = {3'd1, 3'd3};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      wr_valid = 1'b1;
      beat_rand();
      rd_addr  = {3'd1, 3'd1};
      step();
    end
    rd_req   = '0;
    wr_valid = 1'b0;
    chk("load_rvalid", 512'(rd_rvalid), 512'(0));

    // Restart mid-load and reload with a gappy stream.
    pulse_start();
    load_beats(NL * LS, 1'b1);
    step();
    chk("reload_done", 512'(load_done), 512'(1));
    chk("reload_loaded", 512'(leaves_loaded), 512'(NL));
    for (int a = 0; a < 8; a++) begin
      rd_req  = 2'b11;
      rd_addr = {AW'(7 - a), AW'(a)};
      step();
    end
    rd_req = '0;
    rand_reads(100);

    // Asynchronous reset in the middle of a load.
    pulse_start();
    load_beats(12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rand_reads(10);
    chk("post_reset_rvalid", 512'(rd_rvalid), 512'(0));
    pulse_start();
    load_beats(NL * LS, 1'b0);
    rand_reads(100);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
